// File: rtl/control_unit_if.sv
// Strobe/handshake bundle between the Mini-SRC control sequencer and its datapath/memory.
// master = control_unit, slave = datapath side.
interface control_unit_if #(
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Stop;
    logic [31:0]      IR;
    logic             CON_Out;
    logic             Mem_done;

    logic             PCin, IRin, ZLowin, MARin, MDRin, Yin;
    logic             PCout, ZLowout, MDRout, Cout;
    logic             Gra, Grb, Grc, Rin, Rout, BAout;
    logic             Read, Write, IncPC, CON_In;
    logic             HIin, LOin, ZHighin, OutPort, HIout, LOout, ZHighout, InPort;
    logic [4:0]       OP;
    logic             Run;
    logic             Illegal;
    logic [CNT_W-1:0] Instr_count;

    modport master (
        input  Start, Stop, IR, CON_Out, Mem_done,
        output PCin, IRin, ZLowin, MARin, MDRin, Yin,
        output PCout, ZLowout, MDRout, Cout,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Read, Write, IncPC, CON_In,
        output HIin, LOin, ZHighin, OutPort, HIout, LOout, ZHighout, InPort,
        output OP, Run, Illegal, Instr_count
    );

    modport slave (
        output Start, Stop, IR, CON_Out, Mem_done,
        input  PCin, IRin, ZLowin, MARin, MDRin, Yin,
        input  PCout, ZLowout, MDRout, Cout,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Read, Write, IncPC, CON_In,
        input  HIin, LOin, ZHighin, OutPort, HIout, LOout, ZHighout, InPort,
        input  OP, Run, Illegal, Instr_count
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired T0..T7 step sequencer for the Mini-SRC datapath, with memory wait and halt/Stop.
// Optional feature: define CU_ILLEGAL_TRAP_EN to trap unsupported opcodes (sticky Illegal).
module control_unit #(
    parameter int CNT_W = 16
) (
    input  logic            Clock,
    input  logic            Clear,
    control_unit_if.master  cu
);

`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7} state_t;
    typedef enum logic [3:0] {C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_NOP, C_HALT, C_BAD} iclass_t;

    state_t           state, state_nxt;
    iclass_t          iclass;
    logic [4:0]       opcode;
    logic [4:0]       alu_op;
    logic             short_instr;
    logic             retire;
    logic             trap;
    logic             illegal_q;
    logic [CNT_W-1:0] instr_count;
    logic             unused_ir;

    assign opcode    = cu.IR[31:27];
    // Register fields are decoded by the datapath's select logic, not here.
    assign unused_ir = ^cu.IR[26:0];

    always_comb begin
        iclass = C_BAD;
        alu_op = 5'b00011;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00111, 5'b01010, 5'b01011: begin
                iclass = C_ALU;
                alu_op = opcode;
            end
            5'b01100: iclass = C_IMM;
            5'b01101: begin iclass = C_IMM; alu_op = 5'b01010; end
            5'b01110: begin iclass = C_IMM; alu_op = 5'b01011; end
            5'b00001: iclass = C_LDI;
            5'b00000: iclass = C_LD;
            5'b00010: iclass = C_ST;
            5'b10011: iclass = C_BR;
            5'b11010: iclass = C_NOP;
            5'b11011: iclass = C_HALT;
            default:  iclass = C_BAD;
        endcase
    end

    // Without the trap an unsupported opcode retires after fetch exactly like nop.
    assign short_instr = (iclass == C_NOP) || (iclass == C_HALT) || (!TRAP_EN && iclass == C_BAD);

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        trap      = 1'b0;
        case (state)
            IDLE: if (cu.Start && !cu.Stop) state_nxt = T0;
            T0:   state_nxt = T1;
            T1:   if (cu.Mem_done) state_nxt = T2;
            T2:   if (short_instr) retire = 1'b1; else state_nxt = T3;
            T3: begin
                if (TRAP_EN && iclass == C_BAD) begin
                    trap      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = T4;
                end
            end
            T4:   state_nxt = T5;
            T5:   if (iclass == C_LD || iclass == C_ST || iclass == C_BR) state_nxt = T6;
                  else retire = 1'b1;
            T6: begin
                if (iclass == C_BR)                    retire    = 1'b1;
                else if (iclass == C_ST || cu.Mem_done) state_nxt = T7;
            end
            T7:   if (iclass != C_ST || cu.Mem_done) retire = 1'b1;
            default: state_nxt = IDLE;
        endcase
        // Stop is honoured only here, so an instruction in flight always completes.
        if (retire) state_nxt = (iclass == C_HALT || cu.Stop) ? IDLE : T0;
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            instr_count <= '0;
            illegal_q   <= 1'b0;
        end else begin
            if (retire) instr_count <= instr_count + 1'b1;
            if (trap)   illegal_q   <= 1'b1;
        end
    end

    always_comb begin
        cu.PCin = 1'b0; cu.IRin = 1'b0; cu.ZLowin = 1'b0; cu.MARin = 1'b0;
        cu.MDRin = 1'b0; cu.Yin = 1'b0; cu.PCout = 1'b0; cu.ZLowout = 1'b0;
        cu.MDRout = 1'b0; cu.Cout = 1'b0; cu.Gra = 1'b0; cu.Grb = 1'b0;
        cu.Grc = 1'b0; cu.Rin = 1'b0; cu.Rout = 1'b0; cu.BAout = 1'b0;
        cu.Read = 1'b0; cu.Write = 1'b0; cu.IncPC = 1'b0; cu.CON_In = 1'b0;
        cu.OP = 5'b0;
        case (state)
            T0: begin cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; end
            T1: begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
            T2: begin cu.MDRout = 1'b1; cu.IRin = 1'b1; end
            T3: begin
                case (iclass)
                    C_ALU, C_IMM:      begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
                    C_LDI, C_LD, C_ST: begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
                    C_BR:              begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CON_In = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                case (iclass)
                    C_ALU: begin cu.Grc = 1'b1; cu.Rout = 1'b1; cu.ZLowin = 1'b1; cu.OP = alu_op; end
                    C_IMM, C_LDI, C_LD, C_ST: begin cu.Cout = 1'b1; cu.ZLowin = 1'b1; cu.OP = alu_op; end
                    C_BR:  begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                case (iclass)
                    C_ALU, C_IMM, C_LDI: begin cu.ZLowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    C_LD, C_ST:          begin cu.ZLowout = 1'b1; cu.MARin = 1'b1; end
                    C_BR:                begin cu.Cout = 1'b1; cu.ZLowin = 1'b1; cu.OP = alu_op; end
                    default: ;
                endcase
            end
            T6: begin
                case (iclass)
                    C_LD: begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
                    C_ST: begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; end
                    // Branch target lands in PC only when the condition flip-flop agreed.
                    C_BR: begin cu.ZLowout = 1'b1; cu.PCin = cu.CON_Out; end
                    default: ;
                endcase
            end
            T7: begin
                case (iclass)
                    C_LD: begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    C_ST: cu.Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign cu.HIin        = 1'b0;
    assign cu.LOin        = 1'b0;
    assign cu.ZHighin     = 1'b0;
    assign cu.OutPort     = 1'b0;
    assign cu.HIout       = 1'b0;
    assign cu.LOout       = 1'b0;
    assign cu.ZHighout    = 1'b0;
    assign cu.InPort      = 1'b0;
    assign cu.Run         = (state != IDLE);
    assign cu.Illegal     = illegal_q;
    assign cu.Instr_count = instr_count;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each instruction pushes its expected per-cycle strobe
// words, which are popped and compared as the sequencer steps.
module tb_control_unit;
    localparam int CNT_W = 4;

    localparam logic [26:0] B_PCIN    = 27'h0000001;
    localparam logic [26:0] B_IRIN    = 27'h0000002;
    localparam logic [26:0] B_ZLOWIN  = 27'h0000004;
    localparam logic [26:0] B_MARIN   = 27'h0000008;
    localparam logic [26:0] B_MDRIN   = 27'h0000010;
    localparam logic [26:0] B_YIN     = 27'h0000020;
    localparam logic [26:0] B_PCOUT   = 27'h0000040;
    localparam logic [26:0] B_ZLOWOUT = 27'h0000080;
    localparam logic [26:0] B_MDROUT  = 27'h0000100;
    localparam logic [26:0] B_COUT    = 27'h0000200;
    localparam logic [26:0] B_GRA     = 27'h0000400;
    localparam logic [26:0] B_GRB     = 27'h0000800;
    localparam logic [26:0] B_GRC     = 27'h0001000;
    localparam logic [26:0] B_RIN     = 27'h0002000;
    localparam logic [26:0] B_ROUT    = 27'h0004000;
    localparam logic [26:0] B_BAOUT   = 27'h0008000;
    localparam logic [26:0] B_READ    = 27'h0010000;
    localparam logic [26:0] B_WRITE   = 27'h0020000;
    localparam logic [26:0] B_INCPC   = 27'h0040000;
    localparam logic [26:0] B_CONIN   = 27'h0080000;
    localparam logic [26:0] B_RUN     = 27'h0100000;
    localparam logic [26:0] W_T0      = B_RUN | B_PCOUT | B_MARIN | B_INCPC;

    logic Clock;
    logic Clear;

    control_unit_if #(.CNT_W(CNT_W)) cu_bus ();

    control_unit #(.CNT_W(CNT_W)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .cu    (cu_bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int               n_checks;
    int               n_fail;
    logic [CNT_W-1:0] cnt_exp;
    logic             ill_exp;
    logic [26:0]      exp_q[$];
    bit               md_q[$];
    bit               idle;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] opw(input logic [4:0] op);
        return {1'b0, op, 21'b0};
    endfunction

    function automatic logic [26:0] dut_word();
        return {cu_bus.HIin | cu_bus.LOin | cu_bus.ZHighin | cu_bus.OutPort |
                cu_bus.HIout | cu_bus.LOout | cu_bus.ZHighout | cu_bus.InPort,
                cu_bus.OP, cu_bus.Run, cu_bus.CON_In, cu_bus.IncPC, cu_bus.Write,
                cu_bus.Read, cu_bus.BAout, cu_bus.Rout, cu_bus.Rin, cu_bus.Grc,
                cu_bus.Grb, cu_bus.Gra, cu_bus.Cout, cu_bus.MDRout, cu_bus.ZLowout,
                cu_bus.PCout, cu_bus.Yin, cu_bus.MDRin, cu_bus.MARin, cu_bus.ZLowin,
                cu_bus.IRin, cu_bus.PCin};
    endfunction

    task automatic push(input logic [26:0] w, input bit md);
        exp_q.push_back(w);
        md_q.push_back(md);
    endtask

    task automatic push_mem(input logic [26:0] w, input int n);
        repeat (n) push(w, 1'b0);
        push(w, 1'b1);
    endtask

    // Called at a falling edge with the DUT in T0; returns at the falling edge after retirement.
    task automatic exec(input string nm, input logic [31:0] ir, input logic con,
                        input int w1, input int wd, input int stop_at, output bit idle_after);
        logic [4:0]  opc;
        logic [26:0] w;
        bit          counted, halt_i, trap_i;
        int          i;
        opc = ir[31:27];
        counted = 1'b1; halt_i = 1'b0; trap_i = 1'b0;
        cu_bus.IR = ir;
        cu_bus.CON_Out = con;
        push(W_T0, 1'b1);
        push_mem(B_RUN | B_READ | B_MDRIN, w1);
        push(B_RUN | B_MDROUT | B_IRIN, 1'b1);
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00111, 5'b01010, 5'b01011: begin
                push(B_RUN | B_GRB | B_ROUT | B_YIN, 1'b1);
                push(B_RUN | B_GRC | B_ROUT | B_ZLOWIN | opw(opc), 1'b1);
                push(B_RUN | B_ZLOWOUT | B_GRA | B_RIN, 1'b1);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                push(B_RUN | B_GRB | B_ROUT | B_YIN, 1'b1);
                w = (opc == 5'b01100) ? opw(5'b00011) : (opc == 5'b01101) ? opw(5'b01010) : opw(5'b01011);
                push(B_RUN | B_COUT | B_ZLOWIN | w, 1'b1);
                push(B_RUN | B_ZLOWOUT | B_GRA | B_RIN, 1'b1);
            end
            5'b00001, 5'b00000, 5'b00010: begin
                push(B_RUN | B_GRB | B_BAOUT | B_YIN, 1'b1);
                push(B_RUN | B_COUT | B_ZLOWIN | opw(5'b00011), 1'b1);
                if (opc == 5'b00001) begin
                    push(B_RUN | B_ZLOWOUT | B_GRA | B_RIN, 1'b1);
                end else if (opc == 5'b00000) begin
                    push(B_RUN | B_ZLOWOUT | B_MARIN, 1'b1);
                    push_mem(B_RUN | B_READ | B_MDRIN, wd);
                    push(B_RUN | B_MDROUT | B_GRA | B_RIN, 1'b1);
                end else begin
                    push(B_RUN | B_ZLOWOUT | B_MARIN, 1'b1);
                    push(B_RUN | B_GRA | B_ROUT | B_MDRIN, 1'b1);
                    push_mem(B_RUN | B_WRITE, wd);
                end
            end
            5'b10011: begin
                push(B_RUN | B_GRA | B_ROUT | B_CONIN, 1'b1);
                push(B_RUN | B_PCOUT | B_YIN, 1'b1);
                push(B_RUN | B_COUT | B_ZLOWIN | opw(5'b00011), 1'b1);
                push(B_RUN | B_ZLOWOUT | (con ? B_PCIN : 27'h0), 1'b1);
            end
            5'b11010: ;
            5'b11011: halt_i = 1'b1;
            default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                push(B_RUN, 1'b1);
                counted = 1'b0;
                trap_i  = 1'b1;
`endif
            end
        endcase
        i = 0;
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            cu_bus.Mem_done = md_q.pop_front();
            if (stop_at >= 0 && i >= stop_at) cu_bus.Stop = 1'b1;
            check_eq($sformatf("%s_c%0d", nm, i), {5'b0, dut_word()}, {5'b0, w});
            @(posedge Clock);
            @(negedge Clock);
            i++;
        end
        cu_bus.Mem_done = 1'b1;
        if (counted) cnt_exp = cnt_exp + 1'b1;
        if (trap_i)  ill_exp = 1'b1;
        idle_after = halt_i || trap_i || (stop_at >= 0);
        check_eq({nm, "_next"}, {5'b0, dut_word()}, idle_after ? 32'h0 : {5'b0, W_T0});
        check_eq({nm, "_cnt"}, 32'(cu_bus.Instr_count), 32'(cnt_exp));
        check_eq({nm, "_ill"}, {31'b0, cu_bus.Illegal}, {31'b0, ill_exp});
    endtask

    task automatic start_run();
        cu_bus.Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        cu_bus.Start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cnt_exp  = '0;
        ill_exp  = 1'b0;
        Clear = 1'b0;
        cu_bus.Start = 1'b0;
        cu_bus.Stop = 1'b0;
        cu_bus.IR = 32'h0;
        cu_bus.CON_Out = 1'b0;
        cu_bus.Mem_done = 1'b1;
        repeat (2) @(negedge Clock);
        check_eq("rst_word", {5'b0, dut_word()}, 32'h0);
        check_eq("rst_cnt", 32'(cu_bus.Instr_count), 32'h0);
        check_eq("rst_ill", {31'b0, cu_bus.Illegal}, 32'h0);
        Clear = 1'b1;
        start_run();

        exec("add",  32'h1989_0000, 1'b0, 0, 0, -1, idle);
        exec("ori",  32'h7108_0005, 1'b0, 0, 0, -1, idle);
        exec("sub",  32'h2000_0000, 1'b0, 0, 0, -1, idle);
        exec("shl",  32'h3800_0000, 1'b0, 0, 0, -1, idle);
        exec("and",  32'h5000_0000, 1'b0, 0, 0, -1, idle);
        exec("andi", 32'h6880_0007, 1'b0, 0, 0, -1, idle);
        exec("ldi",  32'h0880_0010, 1'b0, 0, 0, -1, idle);
        exec("ld_w", 32'h0080_0010, 1'b0, 0, 3, -1, idle);
        exec("ld_f", 32'h0080_0020, 1'b0, 2, 0, -1, idle);
        exec("st_w", 32'h1080_0030, 1'b0, 0, 2, -1, idle);
        exec("br0",  32'h9880_0004, 1'b0, 0, 0, -1, idle);
        exec("br1s", 32'h9880_0004, 1'b1, 0, 0, 4, idle);

        // Stop still high: Start must be ignored in IDLE.
        cu_bus.Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check_eq("stop_wins", {5'b0, dut_word()}, 32'h0);
        cu_bus.Stop = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        cu_bus.Start = 1'b0;

        exec("nop", 32'hD000_0000, 1'b0, 0, 0, -1, idle);
        exec("bad", 32'hF800_0000, 1'b0, 0, 0, -1, idle);
        if (idle) start_run();
        exec("halt", 32'hD800_0000, 1'b0, 0, 0, -1, idle);
        if (idle) start_run();

        while (cnt_exp != {CNT_W{1'b1}}) exec("fill", 32'hD000_0000, 1'b0, 0, 0, -1, idle);
        exec("wrap", 32'hD000_0000, 1'b0, 0, 0, -1, idle);
        check_eq("wrap_zero", 32'(cu_bus.Instr_count), 32'h0);

        cu_bus.IR = 32'h1989_0000;
        repeat (5) @(posedge Clock);
        @(negedge Clock);
        check_eq("clr_t5", {5'b0, dut_word()}, {5'b0, B_RUN | B_ZLOWOUT | B_GRA | B_RIN});
        Clear = 1'b0;
        #1;
        check_eq("clr_word", {5'b0, dut_word()}, 32'h0);
        check_eq("clr_cnt", 32'(cu_bus.Instr_count), 32'h0);
        check_eq("clr_ill", {31'b0, cu_bus.Illegal}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
